// File: rtl/mips_mc_pkg.sv
// Shared constants for the multicycle MIPS core: instruction encodings,
// ALU operation codes, FSM state encoding and helpers used by the datapath.
package mips_mc_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          NUM_REGS         = 32;
    localparam int          REG_AW           = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_BAD
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL
    } state_t;

    function automatic alu_op_t funct_to_op(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_NOR:  return ALU_NOR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_BAD;
        endcase
    endfunction

    function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                                input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOR: return ~(a | b);
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port; register 0 is hard-wired to zero.
module mc_regfile
    import mips_mc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [31:0]       rd1,
    output logic [31:0]       rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [31:0]       wd
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? 32'd0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core: control FSM, datapath, ALU and register file with a
// req/ready memory port, one memory-mapped GPIO register and an illegal trap.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter int          DataWidth  = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          GPIO_WIDTH = 8,
    parameter logic [31:0] GPIO_ADDR  = 32'h1001_0024
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  mem_we_o,
    output logic                  mem_req_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic [GPIO_WIDTH-1:0] GPIO_o,
    output logic [31:0]           pc_o,
    output logic                  illegal_o
);

    if (DataWidth != 32) begin : g_width_check
        $error("mips_mc_core: only DataWidth=32 is supported");
    end
    if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_gpio_check
        $error("mips_mc_core: GPIO_WIDTH must be 1..32");
    end

    state_t state, next_state;

    logic [31:0]           pc, ir, a_reg, b_reg, alu_out, mdr;
    logic [GPIO_WIDTH-1:0] gpio;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm, rf_rd1, rf_rd2;
    logic        is_gpio;
    alu_op_t     alu_op;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sign_imm = sign_ext(ir[15:0]);
    assign is_gpio  = (alu_out == GPIO_ADDR);
    assign alu_op   = funct_to_op(funct);

    logic        pc_we, ir_we, ab_we, alu_out_we, mdr_we, gpio_we, rf_we;
    logic        req, we;
    logic [31:0] pc_d, pc_clamped, alu_out_d, mdr_d, rf_wdata;
    logic [4:0]  rf_waddr;

    // Every PC update is floored at RESET_PC, including sequential PC+4.
    assign pc_clamped = (pc_d < RESET_PC) ? RESET_PC : pc_d;

    mc_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (rf_we),
        .wa    (rf_waddr),
        .wd    (rf_wdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            gpio    <= '0;
        end else begin
            state <= next_state;
            if (pc_we)      pc      <= pc_clamped;
            if (ir_we)      ir      <= mem_rdata_i;
            if (ab_we)      a_reg   <= rf_rd1;
            if (ab_we)      b_reg   <= rf_rd2;
            if (alu_out_we) alu_out <= alu_out_d;
            if (mdr_we)     mdr     <= mdr_d;
            if (gpio_we)    gpio    <= b_reg[GPIO_WIDTH-1:0];
        end
    end

    always_comb begin
        next_state = state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        ab_we      = 1'b0;
        alu_out_we = 1'b0;
        mdr_we     = 1'b0;
        gpio_we    = 1'b0;
        rf_we      = 1'b0;
        req        = 1'b0;
        we         = 1'b0;
        pc_d       = pc + 32'd4;
        alu_out_d  = alu_out;
        mdr_d      = mem_rdata_i;
        rf_waddr   = rt;
        rf_wdata   = alu_out;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready_i) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_we      = 1'b1;
                alu_out_we = 1'b1;
                alu_out_d  = pc + (sign_imm << 2);
                case (opcode)
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_out_we = 1'b1;
                alu_out_d  = a_reg + sign_imm;
                next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                // The GPIO register is served internally and never reaches the bus.
                if (is_gpio) begin
                    mdr_we     = 1'b1;
                    mdr_d      = 32'(gpio);
                    next_state = S_MEMWB;
                end else begin
                    req = 1'b1;
                    if (mem_ready_i) begin
                        mdr_we     = 1'b1;
                        next_state = S_MEMWB;
                    end
                end
            end
            S_MEMWB: begin
                rf_we      = 1'b1;
                rf_wdata   = mdr;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                if (is_gpio) begin
                    gpio_we    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    req = 1'b1;
                    we  = 1'b1;
                    if (mem_ready_i) next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                if (alu_op == ALU_BAD) begin
                    next_state = S_ILLEGAL;
                end else begin
                    alu_out_we = 1'b1;
                    alu_out_d  = alu_compute(alu_op, a_reg, b_reg);
                    next_state = S_ALUWB;
                end
            end
            S_ALUWB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                if (a_reg == b_reg) begin
                    pc_we = 1'b1;
                    pc_d  = alu_out;
                end
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_out_we = 1'b1;
                alu_out_d  = a_reg + sign_imm;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we      = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_we      = 1'b1;
                pc_d       = {pc[31:28], ir[25:0], 2'b00};
                next_state = S_FETCH;
            end
            S_ILLEGAL: next_state = S_ILLEGAL;
            default:   next_state = S_FETCH;
        endcase
    end

    // Strobes are masked by reset so an access in flight drops at once.
    assign mem_req_o   = req & ~reset;
    assign mem_we_o    = we & ~reset;
    assign mem_addr_o  = (state == S_FETCH) ? pc : alu_out;
    assign mem_wdata_o = b_reg;
    assign GPIO_o      = gpio;
    assign pc_o        = pc;
    assign illegal_o   = (state == S_ILLEGAL) & ~reset;

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: an instruction-level reference model predicts PC,
// GPIO, halt state, timing and every bus write of directed and random code.
module tb_mips_mc_core;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] GPIO_ADDR = 32'h1001_0024;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, pc_o;
  logic        mem_we_o, mem_req_o, mem_ready_i, illegal_o;
  logic [7:0]  GPIO_o;

  mips_mc_core dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_req_o   (mem_req_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .GPIO_o      (GPIO_o),
    .pc_o        (pc_o),
    .illegal_o   (illegal_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state and scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  int          fetch_wait = 0;
  int          data_wait  = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [7:0]  m_gpio;
  logic        m_illegal;
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] v);
    return (v < RESET_PC) ? RESET_PC : v;
  endfunction

  function automatic int wait_for(input logic [31:0] a);
    return (a >= 32'h1000_0000) ? data_wait : fetch_wait;
  endfunction

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [4:0] rand_dst();
    int r;
    r = $urandom_range(0, 31);
    if (r == 10) r = 0;
    return 5'(r);
  endfunction

  function automatic logic [15:0] rand_off();
    return 16'(32'h100 + 4 * $urandom_range(0, 63));
  endfunction

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_regs[r] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc      = RESET_PC;
    m_gpio    = 8'd0;
    m_illegal = 1'b0;
  endtask

  // Architectural effect of one instruction plus its cycle count.
  task automatic model_exec(input logic [31:0] instr, output int lat);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, a, b, pc4, addr, res;
    op   = instr[31:26];
    rs   = instr[25:21];
    rt   = instr[20:16];
    rd   = instr[15:11];
    fn   = instr[5:0];
    simm = {{16{instr[15]}}, instr[15:0]};
    a    = m_regs[rs];
    b    = m_regs[rt];
    lat  = wait_for(m_pc);
    pc4  = clamp(m_pc + 32'd4);
    m_pc = pc4;
    addr = a + simm;
    res  = 32'd0;
    case (op)
      6'h00: begin
        lat += 4;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin
            lat -= 1;
            m_illegal = 1'b1;
          end
        endcase
        if (!m_illegal) set_reg(rd, res);
      end
      6'h23: begin
        lat += 5;
        if (addr == GPIO_ADDR) begin
          set_reg(rt, {24'd0, m_gpio});
        end else begin
          lat += wait_for(addr);
          set_reg(rt, mem_rd(addr));
        end
      end
      6'h2B: begin
        lat += 4;
        if (addr == GPIO_ADDR) begin
          m_gpio = b[7:0];
        end else begin
          lat += wait_for(addr);
          mem[addr] = b;
          exp_q.push_back({addr, b});
        end
      end
      6'h04: begin
        lat += 3;
        if (a == b) m_pc = clamp(pc4 + (simm << 2));
      end
      6'h08: begin
        lat += 4;
        set_reg(rt, a + simm);
      end
      6'h02: begin
        lat += 3;
        m_pc = clamp({pc4[31:28], instr[25:0], 2'b00});
      end
      default: begin
        lat += 2;
        m_illegal = 1'b1;
      end
    endcase
  endtask

  // driver: place instruction at the model PC, run its predicted cycle count, check
  task automatic exec(input logic [31:0] instr);
    int lat;
    mem[m_pc] = instr;
    model_exec(instr, lat);
    repeat (lat) @(posedge clk);
    #1;
    check("pc", pc_o, m_pc);
    check("gpio", {24'd0, GPIO_o}, {24'd0, m_gpio});
    check("illegal", {31'd0, illegal_o}, {31'd0, m_illegal});
    if (!m_illegal) begin
      check("fetch_req", {31'd0, mem_req_o}, 32'd1);
      check("fetch_addr", mem_addr_o, m_pc);
    end else begin
      check("halt_req", {31'd0, mem_req_o}, 32'd0);
    end
  endtask

  // memory responder: wait states, hold checks, write scoreboard
  initial begin : responder
    logic [31:0] held_addr;
    logic        held_we;
    logic [63:0] e;
    int          waited;
    int          target;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'd0;
    waited      = 0;
    held_addr   = 32'd0;
    held_we     = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req_o) begin
        waited      = 0;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
      end else begin
        check("gpio_on_bus", {31'd0, (mem_addr_o == GPIO_ADDR)}, 32'd0);
        target = wait_for(mem_addr_o);
        if (waited == 0) begin
          held_addr = mem_addr_o;
          held_we   = mem_we_o;
        end else begin
          check("hold_addr", mem_addr_o, held_addr);
          check("hold_we", {31'd0, mem_we_o}, {31'd0, held_we});
        end
        if (waited < target) begin
          mem_ready_i = 1'b0;
          mem_rdata_i = $urandom;
          waited++;
        end else begin
          mem_ready_i = 1'b1;
          waited      = 0;
          if (mem_we_o) begin
            mem_rdata_i = $urandom;
            n_tests++;
            assert (exp_q.size() != 0) else begin
              n_fail++;
              $error("FAIL unexpected_write observed=%08h:%08h expected=none", mem_addr_o, mem_wdata_o);
            end
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("wr_addr", mem_addr_o, e[63:32]);
              check("wr_data", mem_wdata_o, e[31:0]);
            end
          end else begin
            mem_rdata_i = mem_rd(mem_addr_o);
          end
        end
      end
    end
  end

  logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  initial begin : main
    model_reset();
    mem[DATA_BASE] = 32'hDEAD_BEEF;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc_o, RESET_PC);
    check("rst_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_illegal", {31'd0, illegal_o}, 32'd0);
    check("rst_gpio", {24'd0, GPIO_o}, 32'd0);
    reset = 1'b0;
    #1;
    check("first_fetch", mem_addr_o, RESET_PC);

    // addi $8,$0,5 then build $10 = 0x10010000
    exec(i_ins(6'h08, 5'd0, 5'd8, 16'd5));
    exec(i_ins(6'h08, 5'd0, 5'd10, 16'h1001));
    repeat (16) exec(r_ins(6'h20, 5'd10, 5'd10, 5'd10));

    // GPIO store/load, then spill the loaded value
    exec(i_ins(6'h2B, 5'd10, 5'd8, 16'h0024));
    check("gpio_value", {24'd0, GPIO_o}, 32'h05);
    exec(i_ins(6'h23, 5'd10, 5'd9, 16'h0024));
    exec(i_ins(6'h2B, 5'd10, 5'd9, 16'h0100));

    // lw with three wait states
    data_wait = 3;
    exec(i_ins(6'h23, 5'd10, 5'd11, 16'h0000));
    data_wait = 0;
    exec(i_ins(6'h2B, 5'd10, 5'd11, 16'h0104));

    // R-type directed values
    exec(i_ins(6'h08, 5'd0, 5'd1, 16'd7));
    exec(i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD));
    exec(r_ins(6'h2A, 5'd3, 5'd2, 5'd1));
    exec(r_ins(6'h22, 5'd4, 5'd1, 5'd2));
    exec(r_ins(6'h27, 5'd5, 5'd1, 5'd2));
    exec(r_ins(6'h24, 5'd6, 5'd1, 5'd2));
    exec(r_ins(6'h25, 5'd7, 5'd1, 5'd2));
    exec(r_ins(6'h20, 5'd0, 5'd1, 5'd2));
    for (int r = 0; r < 8; r++) exec(i_ins(6'h2B, 5'd10, 5'(r), 16'(32'h140 + 4 * r)));

    // branches: taken backwards, not taken, clamped below RESET_PC, jump clamp
    exec(i_ins(6'h04, 5'd1, 5'd1, 16'hFFFE));
    exec(i_ins(6'h04, 5'd1, 5'd2, 16'd5));
    exec({6'h02, 26'(RESET_PC >> 2)});
    exec(i_ins(6'h04, 5'd0, 5'd0, 16'hFFF8));
    exec({6'h02, 26'd0});

    // random mix with random wait states
    for (int k = 0; k < 80; k++) begin
      fetch_wait = $urandom_range(0, 2);
      data_wait  = $urandom_range(0, 2);
      case ($urandom_range(0, 6))
        0: exec(i_ins(6'h08, 5'($urandom_range(0, 31)), rand_dst(), 16'($urandom)));
        1: exec(r_ins(fns[$urandom_range(0, 5)], rand_dst(), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31))));
        2: exec(i_ins(6'h2B, 5'd10, 5'($urandom_range(0, 31)), rand_off()));
        3: exec(i_ins(6'h23, 5'd10, rand_dst(), rand_off()));
        4: exec(i_ins(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      16'(int'($urandom_range(0, 8)) - 4)));
        5: exec(i_ins(6'h2B, 5'd10, 5'($urandom_range(0, 31)), 16'h0024));
        default: exec(i_ins(6'h23, 5'd10, rand_dst(), 16'h0024));
      endcase
    end
    fetch_wait = 0;
    data_wait  = 0;

    // spill the whole register file
    for (int r = 1; r < 32; r++) exec(i_ins(6'h2B, 5'd10, 5'(r), 16'(32'h200 + 4 * r)));

    // illegal opcode halts the core
    exec(32'hFC00_0000);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("frozen_pc", pc_o, m_pc);
      check("frozen_illegal", {31'd0, illegal_o}, 32'd1);
    end

    // reset out of the halt, then reset in the middle of a fetch
    reset = 1'b1;
    #1;
    model_reset();
    check("halt_rst_illegal", {31'd0, illegal_o}, 32'd0);
    check("halt_rst_pc", pc_o, RESET_PC);
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    fetch_wait = 4;
    repeat (2) @(posedge clk);
    #1;
    check("midfetch_req", {31'd0, mem_req_o}, 32'd1);
    reset = 1'b1;
    #1;
    check("midfetch_req_drop", {31'd0, mem_req_o}, 32'd0);
    check("midfetch_pc", pc_o, RESET_PC);
    check("midfetch_illegal", {31'd0, illegal_o}, 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    fetch_wait = 0;

    // registers cleared by reset, then an unknown funct traps
    exec(i_ins(6'h2B, 5'd0, 5'd1, 16'h0108));
    exec(i_ins(6'h2B, 5'd0, 5'd11, 16'h010C));
    exec(r_ins(6'h3F, 5'd1, 5'd1, 5'd1));
    repeat (3) @(posedge clk);
    #1;
    check("funct_trap_pc", pc_o, m_pc);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
- Parametrised successor to the multicycle MIPS datapath: integrates datapath, control FSM, ALU and register file in one core.
- Adds branch and jump support, a wait-state memory handshake, a memory-mapped GPIO register in place of the raw ALU tap, and an illegal-opcode trap.
- Sits between the top level and the external Memory_System; exposes only memory, GPIO and status ports.

Parameters:
- DataWidth, 32, datapath width; only 32 is supported, elaboration error otherwise.
- RESET_PC, 32'h0040_0000, PC after reset; also the PC floor (any PC_next < RESET_PC loads RESET_PC).
- GPIO_WIDTH, 8, width of the GPIO output register (1..32).
- GPIO_ADDR, 32'h1001_0024, word address decoded as the GPIO register.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr_o  out  32  byte address (PC on fetch, ALUOut on data access).
- mem_wdata_o  out  32  store data (register B).
- mem_we_o  out  1  write strobe, valid only with mem_req_o.
- mem_req_o  out  1  access request; held until mem_ready_i.
- mem_rdata_i  in  32  read data, valid when mem_ready_i=1.
- mem_ready_i  in  1  access complete this cycle.
- GPIO_o  out  GPIO_WIDTH  memory-mapped output register.
- pc_o  out  32  current PC (debug).
- illegal_o  out  1  sticky; core halted on an unsupported instruction.

Behaviour:
- Reset (async): PC=RESET_PC; IR, A, B, ALUOut, MDR=0; all 32 registers=0; GPIO_o=0; illegal_o=0; state=FETCH. Outputs deassert immediately, including mid-access.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL.
- FETCH: mem_req_o=1, addr=PC. On mem_ready_i: IR<=mem_rdata_i, PC<=PC+4, go to DECODE. Otherwise hold with all outputs stable.
- DECODE: A<=rs, B<=rt, ALUOut<=PC+(SignImm<<2). Next state by opcode:
  - 0x00 -> EXEC
  - 0x23 or 0x2B -> MEMADR
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEX
  - 0x02 -> JUMP
  - anything else -> ILLEGAL
- MEMADR: ALUOut<=A+SignImm. Then MEMRD for lw, MEMWR for sw.
- MEMRD:
  - If ALUOut==GPIO_ADDR: MDR<=zero-extended GPIO_o, no request, go to MEMWB next cycle.
  - Else: request until ready, MDR<=mem_rdata_i, then MEMWB.
- MEMWB: rt<=MDR; go to FETCH.
- MEMWR:
  - If ALUOut==GPIO_ADDR: GPIO_o<=B[GPIO_WIDTH-1:0], no request.
  - Else: mem_we_o=1 with mem_req_o=1 until ready.
  - Then FETCH.
- EXEC: ALUOut<=A op B. Funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed). Unknown funct -> ILLEGAL.
- ALUWB: rd<=ALUOut; go to FETCH.
- BRANCH: if A==B, PC<=ALUOut; go to FETCH.
- ADDIEX: ALUOut<=A+SignImm. ADDIWB: rt<=ALUOut.
- JUMP: PC<={PC[31:28], IR[25:0], 2'b00}.
- All PC writes are clamped: a value below RESET_PC loads RESET_PC.
- Writes to register 0 are discarded; register 0 always reads 0.
- Arithmetic is 32-bit wrap-around, no overflow trap.
- ILLEGAL: illegal_o=1, no further PC, register, memory or GPIO updates until reset.
- Latency with mem_ready_i tied to 1: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3. Each wait cycle adds one.
- mem_ready_i while mem_req_o=0 is ignored.

Decomposition:
- Package mips_mc_pkg: opcode and funct constants, ALU op encoding, FSM state encoding, RESET_PC default.
- Sub-module mc_regfile: 32x32, two combinational reads, one synchronous write, r0 forced to zero, async reset clears all registers.

Test Plan:
- Reset then ready=1: first fetch at 0x00400000. addi $t0,$0,5 -> $t0=5 after 4 cycles, pc_o=0x00400004.
- sw $t0 to GPIO_ADDR (0x10010024) -> GPIO_o=8'h05, mem_req_o never high during MEMWR. lw from GPIO_ADDR -> rt=5.
- ready held low for 3 cycles during lw from 0x10010000 (holding 0xDEADBEEF) -> mem_req_o/addr stable, rt=0xDEADBEEF after 8 cycles.
- beq equal, offset -2 -> PC=PC+4-8. beq unequal -> PC+4. Branch target below 0x00400000 -> PC=0x00400000.
- R-type: $1=7, $2=-3: slt $3,$2,$1 -> 1; sub -> 10; nor -> ~(7|0xFFFFFFFD). add into $0 -> $0 stays 0.
- Opcode 0x3F -> illegal_o=1, pc_o frozen. Assert reset mid-fetch (req high) -> req drops immediately, PC=RESET_PC, illegal_o=0.
